// File: rtl/i2s_dac_tx.sv
// Stereo serial DAC transmitter: one-entry sample holding register feeding
// left-justified or I2S framing, with bclk/lrck divided down from clk_48.
module i2s_dac_tx #(
  parameter int SAMPLE_W = 16,
  parameter int FRAME_W  = 32,
  parameter int BCLK_DIV = 4,
  parameter int MODE     = 0
) (
  input  logic                       clk_48,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] left_in,
  input  logic signed [SAMPLE_W-1:0] right_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       mute,
  output logic                       bclk,
  output logic                       lrck,
  output logic                       sdata,
  output logic                       underrun
);

  localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(2 * FRAME_W);
  localparam logic [DW-1:0] DCNT_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DCNT_HALF = DW'(BCLK_DIV / 2);
  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(2 * FRAME_W - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] SLOT_W    = BW'(FRAME_W);

  logic [DW-1:0]             dcnt_q, dcnt_d;
  logic [BW-1:0]             bitcnt_q, bitcnt_d;
  logic signed [SAMPLE_W-1:0] shl_q, shl_d, shr_q, shr_d;
  logic signed [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                      hold_valid_q, hold_valid_d;
  logic                      bclk_q, lrck_q, sdata_q, underrun_q, underrun_d;
  logic                      wrap, load;

  // Serial bit for a given bit-counter position; padding bits are zero.
  function automatic logic slot_bit(input logic [BW-1:0]       bc,
                                    input logic [SAMPLE_W-1:0] l,
                                    input logic [SAMPLE_W-1:0] r);
    logic [SAMPLE_W-1:0] chan;
    int k;
    chan = (bc >= SLOT_W) ? r : l;
    k = int'((bc >= SLOT_W) ? (bc - SLOT_W) : bc) - MODE;
    if (k >= 0 && k < SAMPLE_W) begin
      chan = chan << k;
      slot_bit = chan[SAMPLE_W-1];
    end else begin
      slot_bit = 1'b0;
    end
  endfunction

  always_comb begin
    wrap         = (dcnt_q == DCNT_LAST);
    load         = wrap && (bitcnt_q == BIT_LAST);
    dcnt_d       = wrap ? '0 : dcnt_q + DCNT_ONE;
    bitcnt_d     = bitcnt_q;
    shl_d        = shl_q;
    shr_d        = shr_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    hold_valid_d = hold_valid_q;
    underrun_d   = 1'b0;
    if (wrap) begin
      bitcnt_d = load ? '0 : bitcnt_q + BIT_ONE;
    end
    // The load sees the hold as it was at the start of this cycle, so an
    // accept in the same cycle lands in the next frame, never this one.
    if (load) begin
      hold_valid_d = 1'b0;
      if (hold_valid_q && !mute) begin
        shl_d = hold_l_q;
        shr_d = hold_r_q;
      end else begin
        shl_d = '0;
        shr_d = '0;
      end
      underrun_d = !hold_valid_q;
    end
    if (in_valid && !hold_valid_q) begin
      hold_l_d     = left_in;
      hold_r_d     = right_in;
      hold_valid_d = 1'b1;
    end
  end

  // Outputs are registered from next-state counters so they always reflect
  // the current dcnt/bitcnt, changing together with the bclk falling edge.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      dcnt_q       <= '0;
      bitcnt_q     <= '0;
      shl_q        <= '0;
      shr_q        <= '0;
      hold_valid_q <= 1'b0;
      bclk_q       <= 1'b0;
      lrck_q       <= 1'b0;
      sdata_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      dcnt_q       <= dcnt_d;
      bitcnt_q     <= bitcnt_d;
      shl_q        <= shl_d;
      shr_q        <= shr_d;
      hold_valid_q <= hold_valid_d;
      bclk_q       <= (dcnt_d >= DCNT_HALF);
      lrck_q       <= (bitcnt_d >= SLOT_W);
      sdata_q      <= slot_bit(bitcnt_d, shl_d, shr_d);
      underrun_q   <= underrun_d;
    end
  end

  always_ff @(posedge clk_48) begin
    hold_l_q <= hold_l_d;
    hold_r_q <= hold_r_d;
  end

  assign in_ready = ~hold_valid_q;
  assign bclk     = bclk_q;
  assign lrck     = lrck_q;
  assign sdata    = sdata_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx: a left-justified and an I2S instance share
// stimulus; expected frames are queued by the stimulus and checked per frame.
module tb_i2s_dac_tx;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] left_in = '0;
  logic signed [15:0] right_in = '0;
  logic               in_valid = 1'b0;
  logic               mute = 1'b0;
  logic in_ready0, bclk0, lrck0, sdata0, underrun0;
  logic in_ready1, bclk1, lrck1, sdata1, underrun1;

  always #5 clk = ~clk;

  i2s_dac_tx #(.SAMPLE_W(16), .FRAME_W(32), .BCLK_DIV(4), .MODE(0)) dut0 (
    .clk_48(clk), .reset(reset), .left_in(left_in), .right_in(right_in),
    .in_valid(in_valid), .in_ready(in_ready0), .mute(mute), .bclk(bclk0),
    .lrck(lrck0), .sdata(sdata0), .underrun(underrun0));

  i2s_dac_tx #(.SAMPLE_W(16), .FRAME_W(32), .BCLK_DIV(4), .MODE(1)) dut1 (
    .clk_48(clk), .reset(reset), .left_in(left_in), .right_in(right_in),
    .in_valid(in_valid), .in_ready(in_ready1), .mute(mute), .bclk(bclk1),
    .lrck(lrck1), .sdata(sdata1), .underrun(underrun1));

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        ur;
  } frame_t;

  frame_t expq[$];
  int total = 0;
  int passed = 0;
  int cyc = 0;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r, input logic ur);
    frame_t f;
    f.l = l;
    f.r = r;
    f.ur = ur;
    expq.push_back(f);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a sample pair and wait for the handshake; in_valid is left high.
  task automatic send(input logic [15:0] l, input logic [15:0] r, output int acc_cyc);
    int n;
    int c;
    logic acc;
    left_in = l;
    right_in = r;
    in_valid = 1'b1;
    n = 0;
    c = -1;
    acc = 1'b0;
    acc_cyc = -1;
    while (!acc && n < 600) begin
      @(negedge clk);
      acc = in_ready0;
      c = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    if (acc) acc_cyc = c;
    else begin
      total++;
      $display("FAIL send_timeout: no accept after %0d cycles, expected an accept", n);
    end
  endtask

  // Monitor: collect 64 bits per frame on bclk rising edges.
  logic b0[64], b1[64], k0[64], k1[64];
  int   nb = 0;
  int   ur0 = 0;
  int   ur1 = 0;
  int   fidx = 0;
  logic pb = 1'b0;

  task automatic check_frame();
    frame_t e;
    logic [15:0] l0, r0, l1, r1;
    logic sh0, sh1;
    if (expq.size() == 0) begin
      total++;
      $display("FAIL frame%0d_unexpected: got a frame, expected none", fidx);
      return;
    end
    e = expq.pop_front();
    l0 = '0; r0 = '0; l1 = '0; r1 = '0;
    for (int i = 0; i < 16; i++) begin
      l0 = {l0[14:0], b0[i]};
      r0 = {r0[14:0], b0[32+i]};
      l1 = {l1[14:0], b1[1+i]};
      r1 = {r1[14:0], b1[33+i]};
    end
    sh0 = 1'b1;
    sh1 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (k0[i] !== (i >= 32)) sh0 = 1'b0;
      if (k1[i] !== (i >= 32)) sh1 = 1'b0;
      if (!((i < 16) || (i >= 32 && i < 48)) && b0[i] !== 1'b0) sh0 = 1'b0;
      if (!((i >= 1 && i <= 16) || (i >= 33 && i <= 48)) && b1[i] !== 1'b0) sh1 = 1'b0;
    end
    chk($sformatf("f%0d_left_lj", fidx),   32'(l0), 32'(e.l));
    chk($sformatf("f%0d_right_lj", fidx),  32'(r0), 32'(e.r));
    chk($sformatf("f%0d_left_i2s", fidx),  32'(l1), 32'(e.l));
    chk($sformatf("f%0d_right_i2s", fidx), 32'(r1), 32'(e.r));
    chk($sformatf("f%0d_pad_lrck_lj", fidx),  32'(sh0), 32'(1));
    chk($sformatf("f%0d_pad_lrck_i2s", fidx), 32'(sh1), 32'(1));
    chk($sformatf("f%0d_underrun_lj", fidx),  32'(ur0), 32'(e.ur));
    chk($sformatf("f%0d_underrun_i2s", fidx), 32'(ur1), 32'(e.ur));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        nb = 0;
        ur0 = 0;
        ur1 = 0;
        pb = 1'b0;
      end else begin
        if (underrun0) ur0++;
        if (underrun1) ur1++;
        if (bclk0 && !pb) begin
          b0[nb] = sdata0;
          b1[nb] = sdata1;
          k0[nb] = lrck0;
          k1[nb] = lrck1;
          nb++;
          if (nb == 64) begin
            check_frame();
            nb = 0;
            ur0 = 0;
            ur1 = 0;
            fidx++;
          end
        end
        pb = bclk0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ac;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bclk",     32'(bclk0),     32'(0));
    chk("rst_lrck",     32'(lrck0),     32'(0));
    chk("rst_sdata",    32'(sdata0),    32'(0));
    chk("rst_underrun", 32'(underrun0), 32'(0));
    chk("rst_in_ready", 32'(in_ready0), 32'(1));
    chk("rst_sdata_i2s", 32'(sdata1),   32'(0));
    reset = 1'b0;

    push(16'h0000, 16'h0000, 1'b0);
    wait_until(10);
    send(16'hA5C3, 16'h8001, ac);
    in_valid = 1'b0;
    push(16'hA5C3, 16'h8001, 1'b0);
    chk("in_ready_full", 32'(in_ready0), 32'(0));
    wait_until(256);
    chk("in_ready_after_load", 32'(in_ready0), 32'(1));
    push(16'h0000, 16'h0000, 1'b1);

    wait_until(600);
    send(16'h1234, 16'hFEDC, ac);
    in_valid = 1'b0;
    push(16'h1234, 16'hFEDC, 1'b0);

    // Accept lands in the load cycle: that load underruns, sample goes next frame.
    wait_until(1023);
    push(16'h0000, 16'h0000, 1'b1);
    send(16'h0F0F, 16'hF0F0, ac);
    in_valid = 1'b0;
    chk("accept_in_load_cycle", 32'(ac), 32'(1023));
    push(16'h0F0F, 16'hF0F0, 1'b0);

    // Continuous in_valid: one accept per frame, right after each load.
    wait_until(1300);
    send(16'h0001, 16'hFFFF, ac);
    chk("stream_accept0", 32'(ac), 32'(1300));
    push(16'h0001, 16'hFFFF, 1'b0);
    send(16'h8000, 16'h7FFF, ac);
    chk("stream_accept1", 32'(ac), 32'(1536));
    push(16'h8000, 16'h7FFF, 1'b0);
    send(16'h3C3C, 16'hC3C3, ac);
    chk("stream_accept2", 32'(ac), 32'(1792));
    push(16'h3C3C, 16'hC3C3, 1'b0);
    in_valid = 1'b0;

    wait_until(2100);
    mute = 1'b1;
    send(16'h7FFF, 16'h7FFF, ac);
    in_valid = 1'b0;
    push(16'h0000, 16'h0000, 1'b0);
    wait_until(2304);
    mute = 1'b0;
    chk("in_ready_after_mute_load", 32'(in_ready0), 32'(1));
    push(16'h0000, 16'h0000, 1'b1);

    // Frame in flight plus a held sample, then reset in the right slot.
    wait_until(2600);
    send(16'hABCD, 16'h1357, ac);
    in_valid = 1'b0;
    wait_until(2900);
    send(16'h2468, 16'hACE0, ac);
    in_valid = 1'b0;
    wait_until(2980);
    chk("lrck_pre_reset", 32'(lrck0), 32'(1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_bclk",     32'(bclk0),     32'(0));
    chk("midrst_lrck",     32'(lrck0),     32'(0));
    chk("midrst_sdata",    32'(sdata0),    32'(0));
    chk("midrst_underrun", 32'(underrun0), 32'(0));
    chk("midrst_in_ready", 32'(in_ready0), 32'(1));
    chk("midrst_lrck_i2s", 32'(lrck1),     32'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    push(16'h0000, 16'h0000, 1'b0);
    push(16'h0000, 16'h0000, 1'b1);
    wait_until(300);
    send(16'h5A5A, 16'hA5A5, ac);
    in_valid = 1'b0;
    push(16'h5A5A, 16'hA5A5, 1'b0);
    wait_until(780);
    chk("frames_drained", 32'(expq.size()), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
